// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared encodings for the scan_decoder slice.
// The FSM state and scan-direction encodings are plain localparam constants
// so they stay bit-compatible with the older decoder's state registers.
package scan_decoder_pkg;

   // Two-state sequencer encoding
   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t SCAN = 1'b1;

   // Scan direction; only used by the ping-pong build, reset value is UP
   typedef logic dir_t;
   localparam dir_t UP   = 1'b0;
   localparam dir_t DOWN = 1'b1;

endpackage : scan_decoder_pkg

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: purely combinational IN_W -> 2**IN_W one-hot decoder.
// Shared by the direct and scan paths of scan_decoder; feeds the op register.
module onehot_dec #(
   parameter int unsigned IN_W = 4
) (
   input  logic [IN_W-1:0]      a,
   output logic [(2**IN_W)-1:0] y
);

   // Exactly one bit set, selected by the binary address
   always_comb begin
      y    = '0;
      y[a] = 1'b1;
   end

endmodule : onehot_dec

// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with a scan sequencer.
// Direct mode registers onehot(ip); scan mode steps addr through [lo, hi],
// holding each address for dwell+1 enabled cycles.
// Optional feature macro: SCAN_DECODER_PINGPONG_EN (bounce between lo and hi
// instead of wrapping hi -> lo).
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter  int unsigned IN_W    = 4,
   parameter  int unsigned DWELL_W = 8,
   localparam int unsigned OUT_W   = 2**IN_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [IN_W-1:0]    ip,
   input  logic [IN_W-1:0]    lo,
   input  logic [IN_W-1:0]    hi,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               start,
   input  logic               stop,
   output logic [OUT_W-1:0]   op,
   output logic [IN_W-1:0]    addr,
   output logic               busy,
   output logic               wrap,
   output logic               err
);

   state_t               state_q, state_d;
   logic [OUT_W-1:0]     op_q, op_d;
   logic [IN_W-1:0]      addr_q, addr_d;
   logic                 wrap_q, wrap_d;
   logic                 err_q, err_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [IN_W-1:0]      lo_q, lo_d;
   logic [IN_W-1:0]      hi_q, hi_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
`ifdef SCAN_DECODER_PINGPONG_EN
   dir_t                 dir_q, dir_d;
   logic [IN_W-1:0]      step_up, step_dn;
`endif

   logic                 load_op;
   logic                 clr_op;
   logic [OUT_W-1:0]     dec_y;

   // The single decoder looks at the next address, so op and addr always
   // update together from the same registered edge.
   onehot_dec #(
      .IN_W (IN_W)
   ) u_dec (
      .a (addr_d),
      .y (dec_y)
   );

   // Sequencer next-state: direct capture, scan start/reject, dwell and advance
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dwell_d = dwell_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      load_op = 1'b0;
      clr_op  = 1'b0;
`ifdef SCAN_DECODER_PINGPONG_EN
      dir_d   = dir_q;
      step_up = addr_q + IN_W'(1);
      step_dn = addr_q - IN_W'(1);
`endif

      if (state_q == IDLE) begin
         if (en) begin
            if (!mode) begin
               addr_d  = ip;
               load_op = 1'b1;
            end else if (start) begin
               if (lo <= hi) begin
                  lo_d    = lo;
                  hi_d    = hi;
                  dwell_d = dwell;
                  addr_d  = lo;
                  cnt_d   = dwell;
                  load_op = 1'b1;
                  state_d = SCAN;
`ifdef SCAN_DECODER_PINGPONG_EN
                  dir_d   = UP;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      end else begin
         // stop outranks both the enable freeze and the address advance
         if (stop) begin
            state_d = IDLE;
            clr_op  = 1'b1;
         end else if (en) begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else begin
               cnt_d   = dwell_q;
               load_op = 1'b1;
`ifdef SCAN_DECODER_PINGPONG_EN
               // Direction flips on arrival at a bound, so wrap coincides
               // with addr showing hi or lo; a one-address range degenerates
               // to the plain wrap-every-dwell behaviour.
               if (lo_q == hi_q) begin
                  addr_d = lo_q;
                  wrap_d = 1'b1;
               end else if (dir_q == UP) begin
                  addr_d = step_up;
                  if (step_up == hi_q) begin
                     dir_d  = DOWN;
                     wrap_d = 1'b1;
                  end
               end else begin
                  addr_d = step_dn;
                  if (step_dn == lo_q) begin
                     dir_d  = UP;
                     wrap_d = 1'b1;
                  end
               end
`else
               if (addr_q == hi_q) begin
                  addr_d = lo_q;
                  wrap_d = 1'b1;
               end else begin
                  addr_d = addr_q + IN_W'(1);
               end
`endif
            end
         end
      end
   end

   // Output register source: hold, clear on stop, or load the fresh decode
   always_comb begin
      op_d = op_q;
      if (clr_op) begin
         op_d = '0;
      end else if (load_op) begin
         op_d = dec_y;
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         dwell_q <= '0;
`ifdef SCAN_DECODER_PINGPONG_EN
         dir_q   <= UP;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dwell_q <= dwell_d;
`ifdef SCAN_DECODER_PINGPONG_EN
         dir_q   <= dir_d;
`endif
      end
   end

   assign op   = op_q;
   assign addr = addr_q;
   assign busy = (state_q == SCAN);
   assign wrap = wrap_q;
   assign err  = err_q;

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: scoreboard bench for scan_decoder (IN_W=4, DWELL_W=8).
// Expected output tuples are queued as stimulus is driven and popped after
// each clock edge when the DUT's registered outputs are sampled.
module tb_scan_decoder;

   typedef struct packed {
      logic [15:0] op;
      logic [3:0]  addr;
      logic        busy;
      logic        wrap;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        mode = 1'b0;
   logic [3:0]  ip = '0;
   logic [3:0]  lo = '0;
   logic [3:0]  hi = '0;
   logic [7:0]  dwell = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] op;
   logic [3:0]  addr;
   logic        busy;
   logic        wrap;
   logic        err;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   scan_decoder #(
      .IN_W    (4),
      .DWELL_W (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .ip    (ip),
      .lo    (lo),
      .hi    (hi),
      .dwell (dwell),
      .start (start),
      .stop  (stop),
      .op    (op),
      .addr  (addr),
      .busy  (busy),
      .wrap  (wrap),
      .err   (err)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int a, input bit on, input bit b, input bit w, input bit e);
      exp_t r;
      r.op   = on ? (16'h0001 << a) : 16'h0000;
      r.addr = a[3:0];
      r.busy = b;
      r.wrap = w;
      r.err  = e;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, g;
      rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; stop = 1'b0;
      sb.push_back(mk(0, 0, 0, 0, 0));
      tick(); tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL reset_state: got=%h want=%h", g, e); end
      rst = 1'b0; en = 1'b1; mode = 1'b1;
      sb.push_back(mk(0, 0, 0, 0, 0));
      tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL reset_idle_hold: got=%h want=%h", g, e); end
   endtask

   task automatic test_direct();
      exp_t e, g;
      mode = 1'b0; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ip = 4'(i);
         sb.push_back(mk(i, 1, 0, 0, 0));
         tick();
         e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
         if (g !== e) begin bad++; $display("FAIL direct_sweep[%0d]: got=%h want=%h", i, g, e); end
      end
      // en low freezes the registered decode
      en = 1'b0; ip = 4'd3;
      sb.push_back(mk(15, 1, 0, 0, 0));
      tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL direct_freeze: got=%h want=%h", g, e); end
      // start ignored in direct mode
      en = 1'b1; ip = 4'd0; start = 1'b1; lo = 4'd1; hi = 4'd2;
      sb.push_back(mk(0, 1, 0, 0, 0));
      tick();
      start = 1'b0;
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL direct_start_ignored: got=%h want=%h", g, e); end
   endtask

   task automatic test_scan();
      exp_t e, g;
      int seq [13] = '{3, 3, 3, 4, 4, 4, 5, 5, 5, 3, 3, 3, 4};
      mode = 1'b1; en = 1'b1; lo = 4'd3; hi = 4'd5; dwell = 8'd2; start = 1'b1;
      for (int k = 0; k < 13; k++) sb.push_back(mk(seq[k], 1, 1, (k == 9), 0));
      tick();
      // scan parameters and mode must be ignored once scanning
      start = 1'b0; mode = 1'b0; lo = 4'd9; hi = 4'd1; dwell = 8'd7;
      for (int k = 0; k < 13; k++) begin
         if (k > 0) tick();
         e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
         if (g !== e) begin bad++; $display("FAIL scan_seq[%0d]: got=%h want=%h", k, g, e); end
      end
   endtask

   task automatic test_freeze_stop();
      exp_t e, g;
      mode = 1'b1; en = 1'b1;
      sb.push_back(mk(4, 1, 1, 0, 0));
      tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL freeze_pre: got=%h want=%h", g, e); end
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sb.push_back(mk(4, 1, 1, 0, 0));
         tick();
         e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
         if (g !== e) begin bad++; $display("FAIL freeze_hold[%0d]: got=%h want=%h", k, g, e); end
      end
      // resume; start during SCAN is ignored
      en = 1'b1; start = 1'b1; lo = 4'd0; hi = 4'd0; dwell = 8'd0;
      sb.push_back(mk(4, 1, 1, 0, 0));
      tick();
      start = 1'b0;
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL freeze_resume: got=%h want=%h", g, e); end
      sb.push_back(mk(5, 1, 1, 0, 0));
      tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL freeze_advance: got=%h want=%h", g, e); end
      // stop and start together: stop wins
      stop = 1'b1; start = 1'b1; lo = 4'd3; hi = 4'd5; dwell = 8'd2;
      sb.push_back(mk(5, 0, 0, 0, 0));
      tick();
      stop = 1'b0; start = 1'b0;
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL stop_priority: got=%h want=%h", g, e); end
      sb.push_back(mk(5, 0, 0, 0, 0));
      tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL stop_idle_hold: got=%h want=%h", g, e); end
   endtask

   task automatic test_reject_single();
      exp_t e, g;
      mode = 1'b1; en = 1'b1; lo = 4'd9; hi = 4'd2; start = 1'b1;
      sb.push_back(mk(5, 0, 0, 0, 1));
      tick();
      start = 1'b0;
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL reject_err: got=%h want=%h", g, e); end
      sb.push_back(mk(5, 0, 0, 0, 0));
      tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL reject_err_clear: got=%h want=%h", g, e); end
      lo = 4'd7; hi = 4'd7; dwell = 8'd0; start = 1'b1;
      sb.push_back(mk(7, 1, 1, 0, 0));
      for (int k = 0; k < 5; k++) sb.push_back(mk(7, 1, 1, 1, 0));
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
         if (g !== e) begin bad++; $display("FAIL single_addr[%0d]: got=%h want=%h", k, g, e); end
      end
      stop = 1'b1;
      sb.push_back(mk(7, 0, 0, 0, 0));
      tick();
      stop = 1'b0;
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL single_stop: got=%h want=%h", g, e); end
   endtask

   task automatic test_reset_mid();
      exp_t e, g;
      mode = 1'b1; en = 1'b1; lo = 4'd12; hi = 4'd15; dwell = 8'd0; start = 1'b1;
      for (int k = 12; k < 15; k++) sb.push_back(mk(k, 1, 1, 0, 0));
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
         if (g !== e) begin bad++; $display("FAIL rstmid_seq[%0d]: got=%h want=%h", k, g, e); end
      end
      rst = 1'b1; en = 1'b0;
      sb.push_back(mk(0, 0, 0, 0, 0));
      tick();
      rst = 1'b0; en = 1'b1;
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL rstmid_clear: got=%h want=%h", g, e); end
      sb.push_back(mk(0, 0, 0, 0, 0));
      tick();
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL rstmid_idle: got=%h want=%h", g, e); end
   endtask

   task automatic test_bounds();
      exp_t e, g;
`ifdef SCAN_DECODER_PINGPONG_EN
      int s1 [9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
      bit w1 [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
      bit w2 [7] = '{0, 0, 1, 0, 1, 0, 1};
`else
      int s1 [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      bit w1 [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
      bit w2 [7] = '{0, 0, 0, 0, 1, 0, 0};
`endif
      int s2 [7] = '{14, 14, 15, 15, 14, 14, 15};
      mode = 1'b1; en = 1'b1; lo = 4'd0; hi = 4'd3; dwell = 8'd0; start = 1'b1;
      for (int k = 0; k < 9; k++) sb.push_back(mk(s1[k], 1, 1, w1[k], 0));
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick();
         e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
         if (g !== e) begin bad++; $display("FAIL range0_3[%0d]: got=%h want=%h", k, g, e); end
      end
      stop = 1'b1;
      sb.push_back(mk(s1[8], 0, 0, 0, 0));
      tick();
      stop = 1'b0;
      e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
      if (g !== e) begin bad++; $display("FAIL range0_3_stop: got=%h want=%h", g, e); end
      // top of the address space: hi = 15 must not overflow
      lo = 4'd14; hi = 4'd15; dwell = 8'd1; start = 1'b1;
      for (int k = 0; k < 7; k++) sb.push_back(mk(s2[k], 1, 1, w2[k], 0));
      tick();
      start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) tick();
         e = sb.pop_front(); g = {op, addr, busy, wrap, err}; total++;
         if (g !== e) begin bad++; $display("FAIL range14_15[%0d]: got=%h want=%h", k, g, e); end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan();
      test_freeze_stop();
      test_reject_single();
      test_reset_mid();
      test_bounds();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

endmodule : tb_scan_decoder
